uart_rx_cfg: RTL

- Parametrised UART receiver, successor to the fixed-rate serial path used by the UDM debug link in sigma.
- Adds runtime-configurable baud divider, data length, parity mode and stop-bit count.
- Received frames go into an internal FIFO exposed as a valid/ready stream; each entry carries per-frame error flags.
- Sits between the board rx pin and any byte consumer (UDM bridge, CPU-visible UART CSRs).

---
 rtl/uart_rx_cfg_if.sv | 20 ++
 rtl/uart_rx_cfg.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - receive stream interface for uart_rx_cfg
//
// Purpose: carries one received frame from the receiver FIFO head to a consumer.
// Signals:
//   rdata_o  8  received byte, LSB-aligned, unused upper bits zero
//   perr_o   1  parity error flag of the head entry
//   ferr_o   1  framing error flag of the head entry
//   valid_o  1  head entry valid
//   ready_i  1  consumer accepts the head entry
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_cfg_if;
  logic [7:0] rdata_o;
  logic       perr_o;
  logic       ferr_o;
  logic       valid_o;
  logic       ready_i;

  modport master (output rdata_o, perr_o, ferr_o, valid_o, input ready_i);
  modport slave  (input rdata_o, perr_o, ferr_o, valid_o, output ready_i);
endinterface

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable UART receiver with error-flagged receive FIFO
//
// Purpose: samples a serial line with a programmable bit period, data length,
// parity mode and stop-bit count, and queues {perr, ferr, data} per frame.
// Optional build macro: UART_RX_MAJORITY_EN (3-sample majority vote per bit,
// decision one cycle later than the single-sample build).
// Ports:
//   clk_i      system clock
//   srst_n_i   synchronous active-low reset
//   rx_i       serial line, idles high
//   div_i      clock cycles per bit (values below 4 act as 4), latched per frame
//   nbits_i    data length 00=5 .. 11=8, latched per frame
//   parity_i   00/11=none, 01=even, 10=odd, latched per frame
//   stop2_i    1 = two stop bits checked, latched per frame
//   strm       receive stream (rdata_o, perr_o, ferr_o, valid_o, ready_i)
//   ovf_o      sticky overflow flag
//   ovf_clr_i  clears ovf_o (a simultaneous new overflow wins)
//   busy_o     frame FSM not idle
module uart_rx_cfg #(
  parameter int DIV_W       = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                srst_n_i,
  input  logic                rx_i,
  input  logic [DIV_W-1:0]    div_i,
  input  logic [1:0]          nbits_i,
  input  logic [1:0]          parity_i,
  input  logic                stop2_i,
  uart_rx_cfg_if.master       strm,
  output logic                ovf_o,
  input  logic                ovf_clr_i,
  output logic                busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  // ---------------- frame receiver state ----------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs_prev_q, rxs_prev_d;
  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   push_q, push_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [1:0]             nbits_q, nbits_d;
  logic [1:0]             parity_q, parity_d;
  logic                   stop2_q, stop2_d;

  logic                   rxs;
  logic [DIV_W-1:0]       div_eff;
  logic                   tick0;
  logic                   decide;
  logic                   bit_s;
  logic                   par_en;
  logic [2:0]             last_idx;

`ifdef UART_RX_MAJORITY_EN
  logic s1_q, s1_d;
  logic s0_q, s0_d;
  logic pend_q, pend_d;
`endif

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign div_eff  = (div_i < DIV_W'(4)) ? DIV_W'(4) : div_i;
  assign tick0    = (state_q != S_IDLE) && (cnt_q == '0);
  assign par_en   = (parity_q == 2'b01) || (parity_q == 2'b10);
  assign last_idx = {1'b0, nbits_q} + 3'd4;
  assign busy_o   = (state_q != S_IDLE);

  // The bit-period counter keeps its cadence from cnt==0 in both builds;
  // only the point where the sampled value is acted on moves.
`ifdef UART_RX_MAJORITY_EN
  assign decide = pend_q;
  assign bit_s  = (s1_q & s0_q) | (s1_q & rxs) | (s0_q & rxs);
`else
  assign decide = tick0;
  assign bit_s  = rxs;
`endif

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx_i};
    rxs_prev_d = rxs;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    push_d     = 1'b0;
    div_d      = div_q;
    nbits_d    = nbits_q;
    parity_d   = parity_q;
    stop2_d    = stop2_q;
`ifdef UART_RX_MAJORITY_EN
    pend_d     = tick0;
    s0_d       = tick0 ? rxs : s0_q;
    s1_d       = ((state_q != S_IDLE) && (cnt_q == DIV_W'(1))) ? rxs : s1_q;
`endif

    if (state_q != S_IDLE) begin
      cnt_d = tick0 ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
    end

    case (state_q)
      S_IDLE: begin
        // Only a genuine 1->0 transition arms a frame, so a line held low
        // after a break cannot restart reception.
        if (rxs_prev_q && !rxs) begin
          state_d  = S_START;
          cnt_d    = (div_eff >> 1) - DIV_W'(1);
          div_d    = div_eff;
          nbits_d  = nbits_i;
          parity_d = parity_i;
          stop2_d  = stop2_i;
          idx_d    = 3'd0;
          data_d   = 8'h00;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
        end
      end
      S_START: begin
        if (decide) begin
          if (bit_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          data_d[idx_q] = bit_s;
          if (idx_q == last_idx) begin
            state_d = par_en ? S_PARITY : S_STOP1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          perr_d  = ((^data_q) ^ bit_s) != (parity_q == 2'b10);
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (decide) begin
          ferr_d = ferr_q | ~bit_s;
          if (stop2_q) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_IDLE;
            push_d  = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (decide) begin
          ferr_d  = ferr_q | ~bit_s;
          state_d = S_IDLE;
          push_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      data_q     <= 8'h00;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      push_q     <= 1'b0;
      div_q      <= DIV_W'(4);
      nbits_q    <= 2'b11;
      parity_q   <= 2'b00;
      stop2_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s1_q       <= 1'b1;
      s0_q       <= 1'b1;
      pend_q     <= 1'b0;
`endif
    end else begin
      sync_q     <= sync_d;
      rxs_prev_q <= rxs_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      push_q     <= push_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      parity_q   <= parity_d;
      stop2_q    <= stop2_d;
`ifdef UART_RX_MAJORITY_EN
      s1_q       <= s1_d;
      s0_q       <= s0_d;
      pend_q     <= pend_d;
`endif
    end
  end

  // ---------------- receive FIFO with registered head ----------------
  // Occupancy counts the storage entries plus the head register, so the
  // total number of frames held is exactly FIFO_DEPTH.
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fcnt_q, fcnt_d;
  logic [9:0]    head_q, head_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  logic          pop;
  logic [AW:0]   occ;
  logic          full;
  logic          wr_en;
  logic          load;
  logic [9:0]    entry;

  // push_q is asserted the cycle after the final stop decision; the frame
  // registers still hold that frame even if a new start is armed this cycle.
  assign entry = {perr_q, ferr_q, data_q};
  assign pop   = valid_q & strm.ready_i;
  assign occ   = fcnt_q + {{AW{1'b0}}, valid_q};
  assign full  = (occ == (AW+1)'(FIFO_DEPTH));
  assign wr_en = push_q && (!full || pop);
  assign load  = (!valid_q || pop) && (fcnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    head_d   = head_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (load) begin
      head_d   = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else if (pop) begin
      valid_d  = 1'b0;
    end

    case ({wr_en, load})
      2'b10:   fcnt_d = fcnt_q + (AW+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (AW+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase

    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (push_q && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_n_i && wr_en) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign strm.rdata_o = head_q[7:0];
  assign strm.ferr_o  = head_q[8];
  assign strm.perr_o  = head_q[9];
  assign strm.valid_o = valid_q;
  assign ovf_o        = ovf_q;

endmodule
